// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings and read-slave FSM states
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } xresp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axburst_e;

    localparam logic [2:0] SIZE_1B = 3'd0;
    localparam logic [2:0] SIZE_2B = 3'd1;
    localparam logic [2:0] SIZE_4B = 3'd2;
    localparam logic [2:0] SIZE_8B = 3'd3;

    localparam logic [3:0] ID_INSTR = 4'b0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_BEAT = 2'd2;

    // Only FIXED and INCR reach the data path; other burst types are errored.
    function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [1:0]  burst);
        return (burst == BURST_FIXED) ? addr : addr + (64'd1 << size);
    endfunction

endpackage

// File: rtl/axi_mem_rslave_if.sv
// rtl/axi_mem_rslave_if.sv - AXI4 AR/R channel bundle for the read slave
interface axi_mem_rslave_if;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
    );
endinterface

// File: rtl/axi_rslave_mem.sv
// rtl/axi_rslave_mem.sv - synchronous-read word array with preload port and 32-bit replicate mux
module axi_rslave_mem #(
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        we_i,
    input  logic [63:0] waddr_i,
    input  logic [63:0] wdata_i,
    input  logic        re_i,
    input  logic [63:0] raddr_i,
    input  logic [2:0]  size_i,
    output logic [63:0] rdata_o
);
    localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

    logic [63:0] mem_q [DEPTH];
    logic [63:0] word_q;
    logic        hi_q;
    logic        full_q;
    logic [63:0] woff;
    logic [63:0] roff;
    logic        w_ok;
    logic        r_ok;

    assign woff = waddr_i - BASE_ADDR;
    assign roff = raddr_i - BASE_ADDR;
    assign w_ok = we_i && (waddr_i >= BASE_ADDR) && (woff < SPAN);
    assign r_ok = (raddr_i >= BASE_ADDR) && (roff < SPAN);

    // Read and write share the edge; the nonblocking read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (w_ok) begin
            mem_q[woff[IW+2:3]] <= wdata_i;
        end
        if (re_i) begin
            word_q <= r_ok ? mem_q[roff[IW+2:3]] : 64'd0;
            hi_q   <= raddr_i[2];
            full_q <= (size_i == 3'd3);
        end
    end

    assign rdata_o = full_q ? word_q
                   : (hi_q ? {2{word_q[63:32]}} : {2{word_q[31:0]}});
endmodule

// File: rtl/axi_mem_rslave.sv
// rtl/axi_mem_rslave.sv - AXI4 read-only slave memory model, one burst in flight
// Optional: define AXI_RSLAVE_STALL_EN to withhold RVALID pseudo-randomly before each idle beat.
module axi_mem_rslave
    import axi_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             init_we,
    input  logic [63:0]      init_addr,
    input  logic [63:0]      init_wdata,
    axi_mem_rslave_if.slave  axi
);
    localparam logic [3:0]  LAT  = LATENCY[3:0];
    localparam logic [63:0] SPAN = 64'(DEPTH) * 64'd8;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  id_q, id_d;
    logic [63:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  beat_q, beat_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [3:0]  rid_q, rid_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        ok_q, ok_d;

    logic        ar_hs;
    logic        r_hs;
    logic        stall;
    logic        load;
    logic [63:0] nxt_addr;
    logic [63:0] load_addr;
    logic [63:0] load_off;
    logic [7:0]  load_beat;
    logic [1:0]  load_resp;
    logic [63:0] mem_rdata;

`ifdef AXI_RSLAVE_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall = lfsr_q[0];
`else
    assign stall = 1'b0;
`endif

    assign ar_hs    = axi.ARVALID & arready_q;
    assign r_hs     = rvalid_q & axi.RREADY;
    assign nxt_addr = axi_next_addr(addr_q, size_q, burst_q);

    // A beat is loaded either fresh (nothing presented) or as the successor of an accepted beat.
    assign load_addr = rvalid_q ? nxt_addr : addr_q;
    assign load_beat = rvalid_q ? beat_q + 8'd1 : beat_q;
    assign load_off  = load_addr - BASE_ADDR;
    assign load_resp = (burst_q[1] || (size_q > SIZE_8B)) ? RESP_SLVERR
                     : ((load_addr < BASE_ADDR) || (load_off >= SPAN)) ? RESP_DECERR
                     : RESP_OKAY;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        beat_d    = beat_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        ok_d      = ok_q;
        load      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    id_d      = axi.ARID;
                    addr_d    = axi.ARADDR;
                    len_d     = axi.ARLEN;
                    size_d    = axi.ARSIZE;
                    burst_d   = axi.ARBURST;
                    beat_d    = 8'd0;
                    cnt_d     = LAT;
                    arready_d = 1'b0;
                    state_d   = (LAT != 4'd0) ? ST_WAIT : ST_BEAT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_BEAT;
                end
            end
            ST_BEAT: begin
                if (!rvalid_q) begin
                    load = !stall;
                end else if (r_hs) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        load   = 1'b1;
                        addr_d = nxt_addr;
                        beat_d = load_beat;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            rvalid_d = 1'b1;
            rlast_d  = (load_beat == len_q);
            rid_d    = id_q;
            rresp_d  = load_resp;
            ok_d     = (load_resp == RESP_OKAY);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            id_q      <= ID_INSTR;
            addr_q    <= 64'd0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            beat_q    <= 8'd0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= ID_INSTR;
            rresp_q   <= RESP_OKAY;
            ok_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            beat_q    <= beat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            ok_q      <= ok_d;
        end
    end

    axi_rslave_mem #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_mem (
        .clk     (clk),
        .we_i    (init_we),
        .waddr_i (init_addr),
        .wdata_i (init_wdata),
        .re_i    (load),
        .raddr_i (load_addr),
        .size_i  (size_q),
        .rdata_o (mem_rdata)
    );

    // Data is forced to zero for error beats and after reset, when the word register is stale.
    assign axi.ARREADY = arready_q;
    assign axi.RVALID  = rvalid_q;
    assign axi.RLAST   = rlast_q;
    assign axi.RID     = rid_q;
    assign axi.RRESP   = rresp_q;
    assign axi.RDATA   = ok_q ? mem_rdata : 64'd0;
endmodule

// File: tb/tb_axi_mem_rslave.sv
// tb/tb_axi_mem_rslave.sv - randomized bench for axi_mem_rslave against a word-array reference model
module tb_axi_mem_rslave;
    localparam int          DEPTH_T = 64;
    localparam int          LAT_T   = 1;
    localparam logic [63:0] BASE    = 64'h8000_0000;
    localparam logic [63:0] SPAN    = 64'(DEPTH_T) * 64'd8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        init_we = 1'b0;
    logic [63:0] init_addr = 64'd0;
    logic [63:0] init_wdata = 64'd0;

    axi_mem_rslave_if axi ();

    axi_mem_rslave #(
        .DEPTH     (DEPTH_T),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT_T)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .init_we    (init_we),
        .init_addr  (init_addr),
        .init_wdata (init_wdata),
        .axi        (axi)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] model_mem [DEPTH_T];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic in_rng(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < SPAN);
    endfunction

    // {resp, data} the master must see for a beat at byte address a.
    function automatic logic [65:0] exp_beat(input logic [63:0] a, input logic [2:0] s, input logic [1:0] b);
        logic [63:0] w;
        if (b >= 2'd2 || s > 3'd3) return {2'b10, 64'd0};
        if (!in_rng(a)) return {2'b11, 64'd0};
        w = model_mem[int'((a - BASE) >> 3)];
        if (s == 3'd3) return {2'b00, w};
        return {2'b00, a[2] ? {w[63:32], w[63:32]} : {w[31:0], w[31:0]}};
    endfunction

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        @(negedge clk);
        init_we = 1'b1; init_addr = a; init_wdata = d;
        @(negedge clk);
        init_we = 1'b0;
        if (in_rng(a)) model_mem[int'((a - BASE) >> 3)] = d;
    endtask

    // rmode 0: RREADY high except hold_n cycles on beat hold_beat; rmode 1: random RREADY.
    task automatic do_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int rmode,
                            input int hold_beat, input int hold_n, input logic coll,
                            output logic [63:0] d0, output logic [1:0] r0);
        logic [63:0] a;
        logic [65:0] e;
        logic        rdy;
        logic [63:0] cw;
        int          b, c, held, widx;
        bit          done;
        a = addr; b = 0; c = 0; held = 0; done = 0; d0 = '0; r0 = '0;
        cw = '0; widx = 0;
        @(negedge clk);
        axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len; axi.ARSIZE = size;
        axi.ARBURST = burst; axi.ARVALID = 1'b1;
        for (int k = 0; k < 20 && axi.ARREADY !== 1'b1; k++) @(negedge clk);
        if (axi.ARREADY !== 1'b1) begin
            chk("arready_timeout", {63'd0, axi.ARREADY}, 64'd1);
            axi.ARVALID = 1'b0;
            return;
        end
        @(negedge clk);
        axi.ARVALID = 1'b0;
        e = exp_beat(a, size, burst);
        while (!done && c < 200) begin
            if (coll && c == LAT_T) begin
                widx = int'((a - BASE) >> 3);
                cw = ~model_mem[widx];
                init_we = 1'b1; init_addr = {a[63:3], 3'b000}; init_wdata = cw;
            end else if (coll && c == LAT_T + 1) begin
                init_we = 1'b0;
                model_mem[widx] = cw;
            end
            if (c < 1 + LAT_T) begin
                chk("rvalid_before_latency", {63'd0, axi.RVALID}, 64'd0);
                chk("arready_busy", {63'd0, axi.ARREADY}, 64'd0);
            end else begin
                chk("rvalid", {63'd0, axi.RVALID}, 64'd1);
                chk("rid", {60'd0, axi.RID}, {60'd0, id});
                chk("rdata", axi.RDATA, e[63:0]);
                chk("rresp", {62'd0, axi.RRESP}, {62'd0, e[65:64]});
                chk("rlast", {63'd0, axi.RLAST}, {63'd0, (b == int'(len))});
                chk("arready_busy", {63'd0, axi.ARREADY}, 64'd0);
                if (b == 0) begin d0 = axi.RDATA; r0 = axi.RRESP; end
                if (rmode == 1) rdy = ($urandom % 4) != 0;
                else rdy = !(b == hold_beat && held < hold_n);
                if (!rdy) held++;
                axi.RREADY = rdy;
                if (rdy) begin
                    if (b == int'(len)) done = 1;
                    else begin
                        b++;
                        a = (burst == 2'b00) ? a : a + (64'd1 << size);
                        e = exp_beat(a, size, burst);
                    end
                end
            end
            @(negedge clk);
            c++;
        end
        axi.RREADY = 1'b1;
        if (!done) chk("burst_timeout", 64'd0, 64'd1);
        else begin
            chk("rvalid_after_last", {63'd0, axi.RVALID}, 64'd0);
            chk("arready_after_last", {63'd0, axi.ARREADY}, 64'd1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d0, a, tmp;
        logic [65:0] pin;
        logic [1:0]  r0, bb;
        logic [2:0]  s;
        int          off, r;
        axi.ARID = '0; axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = '0;
        axi.ARBURST = '0; axi.ARVALID = 1'b0; axi.RREADY = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_arready", {63'd0, axi.ARREADY}, 64'd0);
        chk("reset_rvalid", {63'd0, axi.RVALID}, 64'd0);
        chk("reset_rlast", {63'd0, axi.RLAST}, 64'd0);
        chk("reset_rid", {60'd0, axi.RID}, 64'd0);
        chk("reset_rdata", axi.RDATA, 64'd0);
        chk("reset_rresp", {62'd0, axi.RRESP}, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("arready_after_reset", {63'd0, axi.ARREADY}, 64'd1);

        for (int i = 0; i < DEPTH_T; i++)
            wr(BASE + 64'(i) * 8, (i == 0) ? 64'h00000013_00100093 : {$urandom, $urandom});
        wr(BASE + SPAN, 64'hDEAD_BEEF_DEAD_BEEF);
        wr(BASE - 64'd8, 64'hBAD0_BAD0_BAD0_BAD0);

        pin = exp_beat(BASE, 3'd2, 2'b01);
        chk("model_pin_w0_lo", pin[63:0], 64'h00100093_00100093);
        pin = exp_beat(BASE + 64'd4, 3'd2, 2'b01);
        chk("model_pin_w0_hi", pin[63:0], 64'h00000013_00000013);

        do_burst(4'd0, BASE, 8'd0, 3'd2, 2'b01, 0, -1, 0, 1'b0, d0, r0);
        chk("lit_w0_lo", d0, 64'h00100093_00100093);
        chk("lit_w0_lo_resp", {62'd0, r0}, 64'd0);
        do_burst(4'd0, BASE + 64'd4, 8'd0, 3'd2, 2'b01, 0, -1, 0, 1'b0, d0, r0);
        chk("lit_w0_hi", d0, 64'h00000013_00000013);
        do_burst(4'd3, BASE, 8'd3, 3'd3, 2'b01, 0, 1, 3, 1'b0, d0, r0);
        chk("lit_incr_w0", d0, 64'h00000013_00100093);
        do_burst(4'd1, 64'h7FFF_FFF8, 8'd1, 3'd3, 2'b01, 0, -1, 0, 1'b0, d0, r0);
        chk("lit_below_data", d0, 64'd0);
        chk("lit_below_resp", {62'd0, r0}, 64'd3);
        do_burst(4'd2, BASE, 8'd1, 3'd3, 2'b10, 0, -1, 0, 1'b0, d0, r0);
        chk("lit_wrap_resp", {62'd0, r0}, 64'd2);
        do_burst(4'd5, BASE + 64'd8, 8'd1, 3'd4, 2'b01, 0, -1, 0, 1'b0, d0, r0);
        chk("lit_size4_resp", {62'd0, r0}, 64'd2);
        do_burst(4'd6, BASE + 64'd16, 8'd2, 3'd3, 2'b00, 0, 0, 2, 1'b0, d0, r0);
        do_burst(4'd7, BASE + SPAN - 64'd8, 8'd1, 3'd3, 2'b01, 0, -1, 0, 1'b0, d0, r0);
        tmp = model_mem[5];
        do_burst(4'd8, BASE + 64'd40, 8'd0, 3'd3, 2'b01, 0, -1, 0, 1'b1, d0, r0);
        chk("collision_old_data", d0, tmp);
        do_burst(4'd8, BASE + 64'd40, 8'd0, 3'd3, 2'b01, 0, -1, 0, 1'b0, d0, r0);
        chk("collision_new_data", d0, ~tmp);

        // Reset while the burst is still in its latency wait.
        @(negedge clk);
        axi.ARID = 4'd9; axi.ARADDR = BASE; axi.ARLEN = 8'd3; axi.ARSIZE = 3'd3;
        axi.ARBURST = 2'b01; axi.ARVALID = 1'b1;
        for (int k = 0; k < 20 && axi.ARREADY !== 1'b1; k++) @(negedge clk);
        @(negedge clk);
        axi.ARVALID = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        chk("midreset_rvalid", {63'd0, axi.RVALID}, 64'd0);
        chk("midreset_arready", {63'd0, axi.ARREADY}, 64'd0);
        chk("midreset_rid", {60'd0, axi.RID}, 64'd0);
        chk("midreset_rdata", axi.RDATA, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("postreset_arready", {63'd0, axi.ARREADY}, 64'd1);
        chk("postreset_rvalid", {63'd0, axi.RVALID}, 64'd0);
        do_burst(4'd4, BASE + 64'd24, 8'd1, 3'd3, 2'b01, 0, -1, 0, 1'b0, d0, r0);

        for (int n = 0; n < 40; n++) begin
            off = $urandom_range(0, DEPTH_T * 8 + 63);
            a = BASE - 64'd32 + 64'(off);
            case ($urandom % 8)
                0: s = 3'd0;
                1: s = 3'd1;
                2, 3: s = 3'd2;
                7: s = 3'd4;
                default: s = 3'd3;
            endcase
            if (s <= 3'd3) a = a & ~((64'd1 << s) - 64'd1);
            r = $urandom % 8;
            bb = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b01;
            do_burst(4'($urandom), a, 8'($urandom % 6), s, bb, 1, -1, 0, 1'b0, d0, r0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
